// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencer for the 5-stage core (IF ID EX MEM WB).
// Decodes the instruction in ID against a small scoreboard of the EX and MEM destinations.
// From that it produces:
//   - ALU operand forward selects, registered so they arrive with the instruction in EX
//   - load-use and branch stalls
//   - an IF/ID flush on a taken branch
//   - the HLT drain / halt sequence
//
// Ports
//   clk           core clock, rising edge
//   rst_n         synchronous reset, active low
//   instr_id      instruction in ID: op=[15:12] rd=[11:8] rs=[7:4] rt=[3:0]
//   id_valid      instr_id is a real instruction (0 = bubble)
//   branch_taken  B/BR in ID resolved taken
//   ForwardA/B    EX operand select: [1]=EX/MEM alu_out, [0]=MEM/WB WriteData, others 0
//   stall         hold PC and IF/ID, bubble into ID/EX (combinational)
//   flush         squash IF/ID (combinational)
//   halted        HLT has retired; sticky until reset
module hazard_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned FWD_W        = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      instr_id,
    input  logic             id_valid,
    input  logic             branch_taken,
    output logic [FWD_W-1:0] ForwardA,
    output logic [FWD_W-1:0] ForwardB,
    output logic             stall,
    output logic             flush,
    output logic             halted
);

    localparam int unsigned CntW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CntW-1:0] CntInit = CntW'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Scoreboard of destinations in EX and MEM
    logic [3:0] ex_rd_q, mem_rd_q;
    logic       ex_wr_q, ex_ld_q, ex_fl_q;
    logic       mem_wr_q, mem_ld_q;

    logic [FWD_W-1:0] fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;

    logic [3:0] op, rd, rs, rt;
    logic [3:0] src_a, src_b;
    logic       is_writer, is_flag, is_load, is_branch, is_br, is_hlt;
    logic       a_ex, b_ex, a_mem, b_mem;
    logic       load_use, br_stall, hazard_stall;

    assign op = instr_id[15:12];
    assign rd = instr_id[11:8];
    assign rs = instr_id[7:4];
    assign rt = instr_id[3:0];

    function automatic logic hit(input logic wr, input logic [3:0] sb_rd, input logic [3:0] src);
        return wr && (sb_rd == src) && (src != 4'd0);
    endfunction

    // Instruction decode; an unused source is forced to R0 so it can never match.
    always_comb begin
        is_writer = (op <= 4'b0111) || (op inside {4'b1000, 4'b1010, 4'b1011, 4'b1110});
        is_flag   = op inside {4'b0000, 4'b0001, 4'b0011, 4'b0100, 4'b0101, 4'b0110};
        is_load   = (op == 4'b1000);
        is_branch = (op == 4'b1100) || (op == 4'b1101);
        is_br     = (op == 4'b1101);
        is_hlt    = (op == 4'b1111);
        src_a     = 4'd0;
        src_b     = 4'd0;
        if (id_valid) begin
            if ((op <= 4'b1001) || (op == 4'b1101)) begin
                src_a = rs;
            end else if ((op == 4'b1010) || (op == 4'b1011)) begin
                src_a = rd;
            end
            if ((op <= 4'b0011) || (op == 4'b0111)) begin
                src_b = rt;
            end
        end
    end

    assign a_ex  = hit(ex_wr_q, ex_rd_q, src_a);
    assign b_ex  = hit(ex_wr_q, ex_rd_q, src_b);
    assign a_mem = hit(mem_wr_q, mem_rd_q, src_a);
    assign b_mem = hit(mem_wr_q, mem_rd_q, src_b);

    assign load_use = (a_ex || b_ex) && ex_ld_q;
    // Branches resolve in ID: wait for flags, and BR also waits for its register value.
    assign br_stall = id_valid && is_branch &&
                      (ex_fl_q || (is_br && (a_ex || (a_mem && mem_ld_q))));
    assign hazard_stall = load_use || br_stall;

    assign stall  = (state_q != StRun) || hazard_stall;
    assign flush  = id_valid && branch_taken && !stall && (state_q == StRun);
    assign halted = (state_q == StHalted);

    // EX match wins over MEM match
    always_comb begin
        fwd_a_d = '0;
        fwd_b_d = '0;
        if (a_ex && !ex_ld_q) begin
            fwd_a_d[1] = 1'b1;
        end else if (a_mem) begin
            fwd_a_d[0] = 1'b1;
        end
        if (b_ex && !ex_ld_q) begin
            fwd_b_d[1] = 1'b1;
        end else if (b_mem) begin
            fwd_b_d[0] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StRun: begin
                if (id_valid && is_hlt && !hazard_stall) begin
                    state_d = StDrain;
                    cnt_d   = CntInit;
                end
            end
            StDrain: begin
                if (cnt_q == '0) begin
                    state_d = StHalted;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StHalted: begin
                state_d = StHalted;
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StRun;
            cnt_q    <= '0;
            ex_rd_q  <= 4'd0;
            ex_wr_q  <= 1'b0;
            ex_ld_q  <= 1'b0;
            ex_fl_q  <= 1'b0;
            mem_rd_q <= 4'd0;
            mem_wr_q <= 1'b0;
            mem_ld_q <= 1'b0;
            fwd_a_q  <= '0;
            fwd_b_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            // A stalled, squashed or absent instruction enters EX as a bubble
            if (stall || !id_valid || flush) begin
                ex_rd_q <= 4'd0;
                ex_wr_q <= 1'b0;
                ex_ld_q <= 1'b0;
                ex_fl_q <= 1'b0;
            end else begin
                ex_rd_q <= rd;
                ex_wr_q <= is_writer && (rd != 4'd0);
                ex_ld_q <= is_load;
                ex_fl_q <= is_flag;
            end
            mem_rd_q <= ex_rd_q;
            mem_wr_q <= ex_wr_q;
            mem_ld_q <= ex_ld_q;
            fwd_a_q  <= stall ? '0 : fwd_a_d;
            fwd_b_q  <= stall ? '0 : fwd_b_d;
        end
    end

    assign ForwardA = fwd_a_q;
    assign ForwardB = fwd_b_q;

endmodule
